// File: rtl/uart_screen_dump.sv
// uart_screen_dump: walks the ROWSxCOLS text RAM and sends each cell as an 8N1 UART frame,
// with CR/LF after every row. Define DUMP_ROWNUM_EN to prefix each row with "<row>:".
module uart_screen_dump #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600,
  parameter int COLS   = 32,
  parameter int ROWS   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [$clog2(ROWS)-1:0] rd_row,
  output logic [$clog2(COLS)-1:0] rd_col,
  input  logic [7:0]              rd_data,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int BW      = $clog2(BIT_CYC + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [BW-1:0] LAST_CYC = BW'(BIT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WAIT, S_LOAD, S_SHIFT, S_CR, S_LF
`ifdef DUMP_ROWNUM_EN
    , S_NUM, S_COLON
`endif
  } state_t;

  // What the serializer is currently sending decides where the stop bit leads.
  typedef enum logic [2:0] {K_CHAR, K_CR, K_LF, K_NUM, K_COLON} kind_t;

`ifdef DUMP_ROWNUM_EN
  localparam state_t ROW_START = S_NUM;
`else
  localparam state_t ROW_START = S_ADDR;
`endif

  function automatic logic [7:0] printable(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      return b;
    end else begin
      return 8'h2E;
    end
  endfunction

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    byte_q, byte_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] cyc_q, cyc_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          launch;
  logic [7:0]    launch_byte;
  kind_t         launch_kind;

  // Next-state, counter and serializer logic
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    row_d       = row_q;
    col_d       = col_q;
    byte_d      = byte_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    cyc_d       = cyc_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    launch      = 1'b0;
    launch_byte = 8'h00;
    launch_kind = K_CHAR;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = ROW_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: state_d = S_WAIT;
      S_WAIT: begin
        byte_d  = printable(rd_data);
        state_d = S_LOAD;
      end
      S_LOAD: begin
        launch      = 1'b1;
        launch_byte = byte_q;
        launch_kind = K_CHAR;
      end
      S_CR: begin
        launch      = 1'b1;
        launch_byte = 8'h0D;
        launch_kind = K_CR;
      end
      S_LF: begin
        launch      = 1'b1;
        launch_byte = 8'h0A;
        launch_kind = K_LF;
      end
`ifdef DUMP_ROWNUM_EN
      S_NUM: begin
        launch      = 1'b1;
        launch_byte = 8'h30 + 8'(row_q);
        launch_kind = K_NUM;
      end
      S_COLON: begin
        launch      = 1'b1;
        launch_byte = 8'h3A;
        launch_kind = K_COLON;
      end
`endif
      S_SHIFT: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (bit_q == 4'd9) begin
            // Stop bit finished: tx stays high through the gap.
            tx_d = 1'b1;
            case (kind_q)
              K_CHAR: begin
                if (col_q == LAST_COL) begin
                  state_d = S_CR;
                end else begin
                  col_d   = col_q + CW'(1);
                  state_d = S_ADDR;
                end
              end
              K_CR: state_d = S_LF;
              K_LF: begin
                if (row_q == LAST_ROW) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
                end else begin
                  row_d   = row_q + RW'(1);
                  col_d   = '0;
                  state_d = ROW_START;
                end
              end
`ifdef DUMP_ROWNUM_EN
              K_NUM:   state_d = S_COLON;
              K_COLON: state_d = S_ADDR;
`endif
              default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end
            endcase
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
          end
        end else begin
          cyc_d = cyc_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Every frame begins here: the start bit goes out on the next edge.
    if (launch) begin
      shift_d = {1'b1, launch_byte};
      kind_d  = launch_kind;
      bit_d   = 4'd0;
      cyc_d   = '0;
      tx_d    = 1'b0;
      state_d = S_SHIFT;
    end else begin
      kind_d = kind_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_CHAR;
      row_q   <= '0;
      col_q   <= '0;
      byte_q  <= 8'h00;
      shift_q <= 9'h1FF;
      bit_q   <= 4'd0;
      cyc_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      row_q   <= row_d;
      col_q   <= col_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd_row = row_q;
  assign rd_col = col_q;
  assign tx     = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_screen_dump.sv
// Self-checking bench for uart_screen_dump: RAM model, UART frame decoder and a
// byte-stream reference built directly from the RAM contents.
module tb_uart_screen_dump;
  localparam int COLS    = 32;
  localparam int ROWS    = 4;
  localparam int BIT_CYC = 10;
  localparam int FRAME   = 10 * BIT_CYC;
`ifdef DUMP_ROWNUM_EN
  localparam int PFX = 2;
  localparam int LAT = 1;
`else
  localparam int PFX = 0;
  localparam int LAT = 3;
`endif
  localparam int LINE = PFX + COLS + 2;
  localparam int N    = ROWS * LINE;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] rd_row;
  logic [4:0] rd_col;
  logic [7:0] rd_data;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] ram [0:ROWS-1][0:COLS-1];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  uart_screen_dump #(
    .CLK_HZ(1000000),
    .BAUD  (100000),
    .COLS  (COLS),
    .ROWS  (ROWS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rd_row (rd_row),
    .rd_col (rd_col),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_data <= ram[rd_row][rd_col];
  end

  // UART decoder / done monitor
  logic [7:0] got_q[$];
  int         st_q[$];
  int         bad_frames, done_cnt, done_cyc, done_bad;
  bit         mon_active;
  int         mon_idx;
  logic       samp [0:FRAME-1];
  logic       prev_done;
  logic [7:0] mon_b;
  bit         mon_ok;

  initial begin
    mon_active = 1'b0; mon_idx = 0; bad_frames = 0; done_cnt = 0;
    done_cyc = -1; done_bad = 0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        if (busy !== 1'b0 || prev_done === 1'b1) done_bad++;
      end
      prev_done = done;
      if (reset !== 1'b0) begin
        mon_active = 1'b0;
      end else if (mon_active) begin
        samp[mon_idx] = tx;
        mon_idx++;
        if (mon_idx == FRAME) begin
          mon_ok = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < BIT_CYC; j++)
              if (samp[k*BIT_CYC+j] !== samp[k*BIT_CYC]) mon_ok = 1'b0;
          if (samp[0] !== 1'b0 || samp[FRAME-1] !== 1'b1) mon_ok = 1'b0;
          for (int k = 0; k < 8; k++) mon_b[k] = samp[(k+1)*BIT_CYC];
          if (!mon_ok) bad_frames++;
          got_q.push_back(mon_b);
          mon_active = 1'b0;
        end
      end else if (tx === 1'b0) begin
        mon_active = 1'b1;
        samp[0]    = 1'b0;
        mon_idx    = 1;
        st_q.push_back(cyc);
      end
    end
  end

  task automatic mon_clear();
    mon_active = 1'b0;
    got_q.delete();
    st_q.delete();
    bad_frames = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    done_bad   = 0;
  endtask

  // Reference: expected byte stream and pre-start gaps straight from the RAM image
  logic [7:0] exp_b[$];
  int         exp_g[$];

  function automatic logic [7:0] shown(input logic [7:0] c);
    return (c < 8'h20 || c > 8'h7E) ? 8'h2E : c;
  endfunction

  task automatic build_expected();
    exp_b.delete();
    exp_g.delete();
    for (int r = 0; r < ROWS; r++) begin
`ifdef DUMP_ROWNUM_EN
      exp_b.push_back(8'h30 + 8'(r)); exp_g.push_back(1);
      exp_b.push_back(8'h3A);         exp_g.push_back(1);
`endif
      for (int c = 0; c < COLS; c++) begin
        exp_b.push_back(shown(ram[r][c]));
        exp_g.push_back(3);
      end
      exp_b.push_back(8'h0D); exp_g.push_back(1);
      exp_b.push_back(8'h0A); exp_g.push_back(1);
    end
  endtask

  task automatic fill_alpha();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) ram[r][c] = 8'h41 + 8'(c);
  endtask

  task automatic pulse_start(output int e);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 e = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    for (int i = 0; i < bound && done_cnt == 0; i++) @(negedge clk);
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: done_cnt=%0d required >0 within %0d cycles", tag, done_cnt, bound);
    end
  endtask

  task automatic check_dump(input int e, input string tag);
    int n;
    n = (got_q.size() < N) ? got_q.size() : N;
    n_checks++;
    if (got_q.size() !== N) begin
      n_fail++; $display("FAIL %s_frames: got %0d required %0d", tag, got_q.size(), N);
    end
    n_checks++;
    if (st_q.size() == 0 || st_q[0] - e !== LAT) begin
      n_fail++; $display("FAIL %s_latency: got %0d required %0d", tag, (st_q.size() == 0) ? -1 : st_q[0] - e, LAT);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (got_q[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL %s_byte[%0d]: got %h required %h", tag, i, got_q[i], exp_b[i]);
      end
    end
    for (int i = 1; i < n; i++) begin
      n_checks++;
      if (st_q[i] - (st_q[i-1] + FRAME) !== exp_g[i]) begin
        n_fail++; $display("FAIL %s_gap[%0d]: got %0d required %0d", tag, i, st_q[i] - (st_q[i-1] + FRAME), exp_g[i]);
      end
    end
    n_checks++;
    if (bad_frames !== 0) begin
      n_fail++; $display("FAIL %s_bit_timing: got %0d malformed frames required 0", tag, bad_frames);
    end
    n_checks++;
    if (done_cnt !== 1 || done_bad !== 0) begin
      n_fail++; $display("FAIL %s_done_pulse: got count %0d bad %0d required 1 and 0", tag, done_cnt, done_bad);
    end
    n_checks++;
    if (n == 0 || done_cyc !== st_q[n-1] + FRAME) begin
      n_fail++; $display("FAIL %s_done_time: got %0d required %0d", tag, done_cyc, (n == 0) ? -1 : st_q[n-1] + FRAME);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_end: got %b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({tx, busy, done, rd_row, rd_col} !== {1'b1, 1'b0, 1'b0, 2'd0, 5'd0}) begin
      n_fail++; $display("FAIL reset_values: got tx=%b busy=%b done=%b row=%0d col=%0d required 1 0 0 0 0", tx, busy, done, rd_row, rd_col);
    end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({tx, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_idle: got tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
  endtask

  task automatic test_full_dump();
    int e;
    fill_alpha();
    build_expected();
    mon_clear();
    pulse_start(e);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL full_busy_rise: got %b required 1", busy);
    end
    wait_done(20000, "full");
    repeat (5) @(negedge clk);
    check_dump(e, "full");
  endtask

  task automatic test_sanitize_ignore_start();
    int e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) ram[r][c] = 8'($urandom_range(0, 255));
    ram[2][5] = 8'h00;
    ram[3][0] = 8'h7F;
    build_expected();
    mon_clear();
    pulse_start(e);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
      @(negedge clk);
      start = (busy === 1'b1 && st_q.size() < N - 2 && ($urandom_range(0, 299) == 0)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++; $display("FAIL sanitize_timeout: done_cnt=%0d required >0", done_cnt);
    end
    repeat (300) @(negedge clk);
    check_dump(e, "sanitize");
    n_checks++;
    if (got_q.size() != N || got_q[2*LINE+PFX+5] !== 8'h2E || got_q[3*LINE+PFX] !== 8'h2E) begin
      n_fail++; $display("FAIL sanitize_cells: got %h %h required 2e 2e",
        (got_q.size() == N) ? got_q[2*LINE+PFX+5] : 8'hxx, (got_q.size() == N) ? got_q[3*LINE+PFX] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e, e2;
    fill_alpha();
    build_expected();
    mon_clear();
    pulse_start(e);
    for (int i = 0; i < 8000 && st_q.size() < 41; i++) @(negedge clk);
    repeat (35) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({tx, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL midreset_async: got tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    end
    @(posedge clk); #1 reset = 1'b0;
    n_checks++;
    if ({rd_row, rd_col} !== 7'd0) begin
      n_fail++; $display("FAIL midreset_addr: got row=%0d col=%0d required 0 0", rd_row, rd_col);
    end
    repeat (200) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0 || st_q.size() !== 41 || bad_frames !== 0) begin
      n_fail++; $display("FAIL midreset_quiet: got done=%0d starts=%0d bad=%0d required 0 41 0", done_cnt, st_q.size(), bad_frames);
    end
    mon_clear();
    pulse_start(e2);
    for (int i = 0; i < 2000 && got_q.size() < 3; i++) @(negedge clk);
    n_checks++;
    if (st_q.size() == 0 || st_q[0] - e2 !== LAT) begin
      n_fail++; $display("FAIL midreset_restart_latency: got %0d required %0d", (st_q.size() == 0) ? -1 : st_q[0] - e2, LAT);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== exp_b[i]) begin
        n_fail++; $display("FAIL midreset_restart_byte[%0d]: got %h required %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_b[i]);
      end
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) ram[r][c] = 8'($urandom_range(32, 126));
    build_expected();
    mon_clear();
    @(posedge clk); #1 start = 1'b1;
    wait_done(20000, "b2b");
    for (int i = 0; i < 1000 && got_q.size() <= N; i++) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (st_q.size() <= N || st_q[N] !== done_cyc + 1 + LAT) begin
      n_fail++; $display("FAIL b2b_restart_time: got %0d required %0d", (st_q.size() > N) ? st_q[N] : -1, done_cyc + 1 + LAT);
    end
    n_checks++;
    if (got_q.size() <= N || got_q[N] !== exp_b[0] || got_q[N-1] !== exp_b[N-1]) begin
      n_fail++; $display("FAIL b2b_bytes: got %h required %h", (got_q.size() > N) ? got_q[N] : 8'hxx, exp_b[0]);
    end
    n_checks++;
    if (done_cnt !== 1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_dump: got done=%0d busy=%b required 1 1", done_cnt, busy);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) ram[r][c] = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_full_dump();
    test_sanitize_ignore_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
